// File: rtl/serial_mult_pkg.sv
// Shared types and default sizes for the serial multiplier issue/collect stage.
// The timeout watchdog in the top is enabled by defining MUL_TIMEOUT_EN.
package serial_mult_pkg;

  localparam int MUL_WIDTH       = 7;
  localparam int FIFO_DEPTH      = 4;
  localparam int WATCHDOG_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

  typedef struct packed {
    logic [MUL_WIDTH-1:0] a;
    logic [MUL_WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/serial_mult_op_fifo.sv
// Synchronous operand FIFO: DEPTH entries of DATA_W bits, head visible without a pop.
// Full flag is registered, so a push into a full FIFO is refused even when a pop happens.
module serial_mult_op_fifo #(
  parameter int DATA_W  = 14,
  parameter int DEPTH   = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              full_reg;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_reg == '0);
  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign full      = full_reg;

endmodule

// File: rtl/serial_mult_issue_ctrl.sv
// Issue/collect stage for the serial multiplier: queues operand pairs, runs one multiply
// at a time, returns products on a valid/ready port. Define MUL_TIMEOUT_EN for the watchdog.
module serial_mult_issue_ctrl
  import serial_mult_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int DEPTH   = FIFO_DEPTH,
  parameter int TIMEOUT = WATCHDOG_CYCLES,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_en,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_valid,
  input  logic [2*WIDTH-1:0] mul_s,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_s,
  output logic               out_err,
  output logic               busy,
  output logic [CNT_W-1:0]   fifo_count
);

  state_t               state_reg;
  state_t               state_next;
  logic [WIDTH-1:0]     mul_a_reg;
  logic [WIDTH-1:0]     mul_a_next;
  logic [WIDTH-1:0]     mul_b_reg;
  logic [WIDTH-1:0]     mul_b_next;
  logic [2*WIDTH-1:0]   out_s_reg;
  logic [2*WIDTH-1:0]   out_s_next;
  logic                 out_valid_reg;
  logic                 out_valid_next;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*WIDTH-1:0]   fifo_head;

`ifdef MUL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0]     timer_reg;
  logic [TMR_W-1:0]     timer_next;
  logic                 out_err_reg;
  logic                 out_err_next;
`else
  logic                 unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  serial_mult_op_fifo #(
    .DATA_W (2*WIDTH),
    .DEPTH  (DEPTH)
  ) u_op_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next     = state_reg;
    mul_a_next     = mul_a_reg;
    mul_b_next     = mul_b_reg;
    out_s_next     = out_s_reg;
    out_valid_next = out_valid_reg;
    fifo_pop       = 1'b0;
`ifdef MUL_TIMEOUT_EN
    timer_next     = timer_reg;
    out_err_next   = out_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop                 = 1'b1;
          {mul_a_next, mul_b_next} = fifo_head;
          state_next               = ISSUE;
        end
      end
      ISSUE: begin
        state_next = SETTLE;
`ifdef MUL_TIMEOUT_EN
        timer_next = '0;
`endif
      end
      // The multiplier's valid can still be high from the previous product here.
      SETTLE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (mul_valid) begin
          out_s_next     = mul_s;
          out_valid_next = 1'b1;
          state_next     = HOLD;
`ifdef MUL_TIMEOUT_EN
          out_err_next   = 1'b0;
`endif
        end
`ifdef MUL_TIMEOUT_EN
        else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
          out_s_next     = '0;
          out_err_next   = 1'b1;
          out_valid_next = 1'b1;
          state_next     = HOLD;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
`endif
      end
      HOLD: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
`ifdef MUL_TIMEOUT_EN
          out_err_next   = 1'b0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mul_a_reg     <= '0;
      mul_b_reg     <= '0;
      out_s_reg     <= '0;
      out_valid_reg <= 1'b0;
`ifdef MUL_TIMEOUT_EN
      timer_reg     <= '0;
      out_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      mul_a_reg     <= mul_a_next;
      mul_b_reg     <= mul_b_next;
      out_s_reg     <= out_s_next;
      out_valid_reg <= out_valid_next;
`ifdef MUL_TIMEOUT_EN
      timer_reg     <= timer_next;
      out_err_reg   <= out_err_next;
`endif
    end
  end

  // Gate with rst so a reset landing on ISSUE never launches an operation.
  assign mul_en    = (state_reg == ISSUE) && !rst;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign out_valid = out_valid_reg;
  assign out_s     = out_s_reg;
  assign in_ready  = !fifo_full;
  assign busy      = (state_reg != IDLE) || !fifo_empty;
`ifdef MUL_TIMEOUT_EN
  assign out_err   = out_err_reg;
`else
  assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mult_issue_ctrl.sv
// Directed bench for serial_mult_issue_ctrl with a behavioural serial multiplier model.
// Timeout cases are included when MUL_TIMEOUT_EN is defined.
module tb_serial_mult_issue_ctrl;
  import serial_mult_pkg::*;

  localparam int W  = 7;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          mul_en;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic          mul_valid = 1'b0;
  logic [2*W-1:0] mul_s = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_s;
  logic          out_err;
  logic          busy;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  serial_mult_issue_ctrl #(.WIDTH(W), .DEPTH(D), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid(mul_valid), .mul_s(mul_s), .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_err(out_err), .busy(busy), .fifo_count(fifo_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Multiplier model and transaction monitor state
  int            mdl_delay = 8;
  bit            mdl_hold  = 1'b0;
  bit            mdl_never = 1'b0;
  int            mdl_cnt   = 0;
  int            mdl_stale = 0;
  logic [2*W-1:0] mdl_prod = '0;
  int            en_count  = 0;
  int            res_count = 0;
  int            en_idx    = 0;
  bit            in_flight = 1'b0;
  logic [W-1:0]  pa_q[$];
  logic [W-1:0]  pb_q[$];
  logic [2*W-1:0] exp_s_q[$];
  logic          exp_e_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (mul_en) begin
        en_count++;
        $display("issue  a=%0d b=%0d", mul_a, mul_b);
        check_eq("single_in_flight", in_flight, 0);
        check_eq("issue_pending", en_idx < pa_q.size(), 1);
        if (en_idx < pa_q.size()) begin
          check_eq("issue_a", mul_a, pa_q[en_idx]);
          check_eq("issue_b", mul_b, pb_q[en_idx]);
        end
        en_idx++;
        in_flight = 1'b1;
      end else if (in_flight && en_idx > 0) begin
        check_eq("stable_a", mul_a, pa_q[en_idx-1]);
        check_eq("stable_b", mul_b, pb_q[en_idx-1]);
      end
      if (out_valid && out_ready) begin
        res_count++;
        in_flight = 1'b0;
        $display("result s=%0d err=%0d", out_s, out_err);
        check_eq("result_pending", exp_s_q.size() > 0, 1);
        if (exp_s_q.size() > 0) begin
          check_eq("result_s", out_s, exp_s_q.pop_front());
          check_eq("result_err", out_err, exp_e_q.pop_front());
        end
      end
    end
    // Model: optional stale valid held into SETTLE, then product after mdl_delay cycles.
    if (rst) begin
      mdl_cnt   = 0;
      mdl_stale = 0;
      mul_valid = 1'b0;
    end else if (mul_en) begin
      mdl_prod  = (2*W)'(mul_a) * (2*W)'(mul_b);
      mdl_cnt   = mdl_delay;
      mdl_stale = mdl_hold ? 2 : 0;
      if (!mdl_hold) mul_valid = 1'b0;
    end else begin
      if (mdl_stale > 0) begin
        mdl_stale--;
        if (mdl_stale == 0) mul_valid = 1'b0;
      end else if (!mdl_hold && mul_valid) begin
        mul_valid = 1'b0;
      end
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0 && !mdl_never) begin
          mul_valid = 1'b1;
          mul_s     = mdl_prod;
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] s, input logic e);
    bit ok;
    ok = 1'b0;
    pa_q.push_back(a);
    pb_q.push_back(b);
    exp_s_q.push_back(s);
    exp_e_q.push_back(e);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("push   a=%0d b=%0d", a, b);
    check_eq("push_accepted", ok, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_s_q.size() > 0; i++) @(negedge clk);
    check_eq("drain_remaining", exp_s_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model_queues();
    pa_q.delete();
    pb_q.delete();
    exp_s_q.delete();
    exp_e_q.delete();
    en_idx    = 0;
    in_flight = 1'b0;
  endtask

  operand_pair_t  cor_p [3];
  logic [2*W-1:0] cor_s [3];
  operand_pair_t  bp_p  [6];
  logic [2*W-1:0] bp_s  [6];
  int e0;
  int r0;

  initial begin
    cor_p[0] = '{a: 7'd127, b: 7'd127}; cor_s[0] = 14'd16129;
    cor_p[1] = '{a: 7'd0,   b: 7'd55};  cor_s[1] = 14'd0;
    cor_p[2] = '{a: 7'd1,   b: 7'd127}; cor_s[2] = 14'd127;
    bp_p[0] = '{a: 7'd2,   b: 7'd3};  bp_s[0] = 14'd6;
    bp_p[1] = '{a: 7'd4,   b: 7'd5};  bp_s[1] = 14'd20;
    bp_p[2] = '{a: 7'd10,  b: 7'd11}; bp_s[2] = 14'd110;
    bp_p[3] = '{a: 7'd12,  b: 7'd12}; bp_s[3] = 14'd144;
    bp_p[4] = '{a: 7'd100, b: 7'd2};  bp_s[4] = 14'd200;
    bp_p[5] = '{a: 7'd6,   b: 7'd7};  bp_s[5] = 14'd42;

    // Reset for 4 cycles
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_out_s", out_s, 0);
    check_eq("rst_mul_en", mul_en, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_b", mul_b, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_fifo_count", fifo_count, 0);
    @(posedge clk);
    #1;

    // Basic (7,9) with latency: pop the cycle after acceptance, mul_en the cycle after that
    e0 = en_count;
    push(7'd7, 7'd9, 14'd63, 1'b0);
    @(negedge clk);
    check_eq("lat_pop_cycle_en", mul_en, 0);
    check_eq("lat_pop_cycle_count", fifo_count, 1);
    check_eq("lat_busy", busy, 1);
    @(negedge clk);
    check_eq("lat_issue_en", mul_en, 1);
    check_eq("lat_issue_count", fifo_count, 0);
    wait_drain(100);
    check_eq("basic_en_pulses", en_count - e0, 1);

    // Corner operands
    e0 = en_count;
    for (int i = 0; i < 3; i++) push(cor_p[i].a, cor_p[i].b, cor_s[i], 1'b0);
    wait_drain(200);
    check_eq("corner_en_pulses", en_count - e0, 3);

    // Back-pressure: result stalled, FIFO fills to DEPTH
    e0 = en_count;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(bp_p[i].a, bp_p[i].b, bp_s[i], 1'b0);
    repeat (20) @(negedge clk);
    check_eq("bp_fifo_count", fifo_count, 4);
    check_eq("bp_in_ready", in_ready, 0);
    check_eq("bp_out_valid", out_valid, 1);
    check_eq("bp_held_s", out_s, 6);
    repeat (3) @(negedge clk);
    check_eq("bp_held_s_later", out_s, 6);
    check_eq("bp_en_pulses_stalled", en_count - e0, 1);
    fork
      push(bp_p[5].a, bp_p[5].b, bp_s[5], 1'b0);
      begin
        repeat (4) @(negedge clk);
        check_eq("bp_still_full", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain(400);
    check_eq("bp_en_pulses", en_count - e0, 6);

    // Stale mul_valid held high into SETTLE of the next op
    e0 = en_count;
    r0 = res_count;
    mdl_hold = 1'b1;
    push(7'd5, 7'd6, 14'd30, 1'b0);
    push(7'd8, 7'd9, 14'd72, 1'b0);
    push(7'd3, 7'd3, 14'd9, 1'b0);
    wait_drain(200);
    repeat (30) @(negedge clk);
    check_eq("stale_results", res_count - r0, 3);
    check_eq("stale_en_pulses", en_count - e0, 3);
    mdl_hold = 1'b0;
    @(posedge clk);
    #1;

    // Reset during WAIT with 3 pairs queued
    mdl_delay = 30;
    push(7'd2, 7'd2, 14'd4, 1'b0);
    push(7'd3, 7'd4, 14'd12, 1'b0);
    push(7'd5, 7'd5, 14'd25, 1'b0);
    push(7'd6, 7'd6, 14'd36, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("midop_fifo_count", fifo_count, 3);
    check_eq("midop_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midop_rst_mul_en", mul_en, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model_queues();
    e0 = en_count;
    r0 = res_count;
    @(negedge clk);
    check_eq("midop_after_out_valid", out_valid, 0);
    check_eq("midop_after_fifo_count", fifo_count, 0);
    check_eq("midop_after_busy", busy, 0);
    check_eq("midop_after_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    check_eq("midop_no_en", en_count - e0, 0);
    check_eq("midop_no_result", res_count - r0, 0);
    mdl_delay = 8;
    @(posedge clk);
    #1;

`ifdef MUL_TIMEOUT_EN
    // Multiplier never answers: watchdog returns an error result, next op is normal
    mdl_never = 1'b1;
    push(7'd9, 7'd9, 14'd0, 1'b1);
    wait_drain(200);
    mdl_never = 1'b0;
    push(7'd3, 7'd5, 14'd15, 1'b0);
    wait_drain(100);
`else
    // Without the watchdog WAIT holds indefinitely
    mdl_never = 1'b1;
    push(7'd9, 7'd9, 14'd81, 1'b0);
    repeat (100) @(negedge clk);
    check_eq("nowdog_out_valid", out_valid, 0);
    check_eq("nowdog_busy", busy, 1);
    check_eq("nowdog_out_err", out_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model_queues();
    mdl_never = 1'b0;
    push(7'd3, 7'd5, 14'd15, 1'b0);
    wait_drain(100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got %0d checks, simulation did not finish", n_checks);
    $fatal(1, "time limit");
  end

endmodule
